// File: rtl/uart_time_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_time_cmd_parser
//   Parses time-set frames arriving byte by byte from a UART receiver.
//   Frame: 'T' H H M M S S '\n'  (digits ASCII '0'-'9'); '\r' is ignored
//   anywhere. A 'T' at any point restarts the frame. An accepted, in-range
//   frame updates the time outputs together with a one-cycle set_valid pulse.
//   A malformed frame, an out-of-range time or an inter-byte timeout gives a
//   one-cycle err pulse.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous reset, active low
//   rx_data    in   8  received byte
//   rx_valid   in   1  rx_data valid this cycle (may be high every cycle)
//   set_hour   out  5  last accepted hour   (0-23)
//   set_min    out  6  last accepted minute (0-59)
//   set_sec    out  6  last accepted second (0-59)
//   set_valid  out  1  one-cycle pulse when the time outputs update
//   err        out  1  one-cycle pulse when a frame is rejected
//   busy       out  1  a frame is in progress
// -----------------------------------------------------------------------------
module uart_time_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       set_valid,
  output logic       err,
  output logic       busy
);

  localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      CH_T     = 8'h54;
  localparam logic [7:0]      CH_LF    = 8'h0A;
  localparam logic [7:0]      CH_CR    = 8'h0D;

  typedef enum logic [1:0] {IDLE, DIGITS, TERM} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] dig_q, dig_d;     // H10 H1 M10 M1 S10 S1
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            set_valid_q, set_valid_d;
  logic            err_q, err_d;

  logic [6:0]      hour7, min7, sec7;
  logic            range_ok;
  logic            is_digit;

  function automatic logic [6:0] compose(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  // Values are built at full 7-bit width so e.g. "99" is rejected rather than
  // wrapping into range after truncation.
  assign hour7    = compose(dig_q[0], dig_q[1]);
  assign min7     = compose(dig_q[2], dig_q[3]);
  assign sec7     = compose(dig_q[4], dig_q[5]);
  assign range_ok = (hour7 <= 7'd23) && (min7 <= 7'd59) && (sec7 <= 7'd59);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dig_d       = dig_q;
    tmo_d       = tmo_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    set_valid_d = 1'b0;
    err_d       = 1'b0;

    if (rx_valid) begin
      // A received byte always wins over a coincident timeout.
      tmo_d = '0;
      if (rx_data == CH_CR) begin
        // ignored everywhere
      end else if (rx_data == CH_T) begin
        state_d = DIGITS;
        idx_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          DIGITS: begin
            if (is_digit) begin
              // For '0'-'9' the low nibble equals byte - 0x30.
              dig_d[idx_q] = rx_data[3:0];
              if (idx_q == 3'd5) begin
                state_d = TERM;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
              idx_d   = '0;
            end
          end
          TERM: begin
            if ((rx_data == CH_LF) && range_ok) begin
              hour_d      = hour7[4:0];
              min_d       = min7[5:0];
              sec_d       = sec7[5:0];
              set_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
            idx_d   = '0;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        idx_d   = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      // NOTE: the digit store is only six nibbles, so it is reset along with
      // everything else; it is never read before being rewritten anyway.
      dig_q       <= '0;
      tmo_q       <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      set_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dig_q       <= dig_d;
      tmo_q       <= tmo_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      set_valid_q <= set_valid_d;
      err_q       <= err_d;
    end
  end

  assign set_hour  = hour_q;
  assign set_min   = min_q;
  assign set_sec   = sec_q;
  assign set_valid = set_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_time_cmd_parser.md
UART_TIME_CMD_PARSER -- requirements
Module: uart_time_cmd_parser

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, meaning idle cycles allowed between bytes of one frame before abort.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-005 The block SHALL have port rx_valid  input  1  one-cycle pulse; rx_data valid in that cycle.
REQ-006 The block SHALL have port set_hour  output  5  last accepted hour, 0-23.
REQ-007 The block SHALL have port set_min  output  6  last accepted minute, 0-59.
REQ-008 The block SHALL have port set_sec  output  6  last accepted second, 0-59.
REQ-009 The block SHALL have port set_valid  output  1  one-cycle pulse when set_hour/min/sec are updated.
REQ-010 The block SHALL have port err  output  1  one-cycle pulse on any frame rejection.
REQ-011 The block SHALL have port busy  output  1  high whenever a frame is in progress (state not IDLE).

Function
REQ-012 Frame format SHALL be ASCII 'T' (0x54), six digits HHMMSS ('0'-'9'), then '\n' (0x0A).
REQ-013 Byte 0x0D SHALL be ignored in every state, with no state, counter or timeout change other than timeout reload.
REQ-014 States SHALL be IDLE, DIGITS, TERM; transitions occur only on cycles with rx_valid=1 or timeout expiry.
REQ-015 IDLE: 'T' -> DIGITS with digit index 0; any other byte -> stay IDLE, no err.
REQ-016 DIGITS: digit byte -> store value (byte-0x30) at current index, index+1; after index 5 stored -> TERM.
REQ-017 DIGITS: non-digit byte other than 'T' -> err pulse, IDLE.
REQ-018 TERM: '\n' -> range check; any other byte other than 'T' -> err pulse, IDLE.
REQ-019 A 'T' received in DIGITS or TERM SHALL restart the frame (DIGITS, index 0) with no err pulse.
REQ-020 Values SHALL be composed as tens*10+ones in 7-bit arithmetic before range check, then truncated to output width.
REQ-021 Range check SHALL pass only if hour<=23, minute<=59, second<=59; pass -> outputs updated and set_valid pulse; fail -> err pulse, outputs unchanged; both -> IDLE.
REQ-022 set_valid/err SHALL assert in the cycle after the rx_valid cycle carrying '\n' (or offending byte), for exactly one cycle.
REQ-023 set_valid and err SHALL never assert in the same cycle.
REQ-024 set_hour/min/sec SHALL change only together, in the same cycle set_valid is asserted, and hold otherwise.
REQ-025 Timeout counter SHALL reload on every rx_valid and count while busy; reaching TIMEOUT_CYCLES-1 without rx_valid -> err pulse, IDLE.
REQ-026 If rx_valid coincides with timeout expiry, the byte SHALL be processed and the timeout ignored.
REQ-027 rx_valid pulses SHALL be accepted back-to-back (every cycle) with no byte loss.

Reset
REQ-028 Asserting reset (low) SHALL immediately force IDLE, index 0, timeout counter 0, set_hour/min/sec=0, set_valid=0, err=0, busy=0.
REQ-029 Reset mid-frame SHALL discard the partial frame with no err or set_valid pulse after release.
REQ-030 First rx_valid SHALL be honoured on the first rising clk edge after reset deasserts.

Verification
REQ-031 Bytes "T123456\n" -> one set_valid pulse, set_hour=12, set_min=34, set_sec=56, err never high.
REQ-032 Bytes "T245900\n" -> one err pulse on cycle after '\n', outputs keep prior values, no set_valid.
REQ-033 Bytes "T12T235959\r\n" -> no err, one set_valid, outputs 23/59/59.
REQ-034 Bytes "T12" then no bytes for TIMEOUT_CYCLES (bench uses 1000) -> err pulse once, busy falls; then "T000000\n" -> set_valid, outputs 0/0/0.
REQ-035 Bytes "T12A" -> err pulse cycle after 'A', IDLE; reset pulsed low during "T1234" -> busy=0, outputs 0, no pulses.
